// File: rtl/canvas_painter_pkg.sv
// canvas_painter_pkg: shared RGB565 colours, OLED geometry, FSM state type and pixel index helpers
package canvas_painter_pkg;
    localparam int OLED_W = 96;
    localparam int OLED_H = 64;
    localparam int MENU_Y0 = 54;
    localparam int PIX_N = OLED_W * OLED_H;
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE = 16'h001F;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] CYAN = 16'h07FF;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    typedef enum logic {IDLE, CLEAR} state_t;
    function automatic logic [12:0] xy_to_idx(input logic [6:0] x, input logic [5:0] y);
        return 13'(y) * 13'(OLED_W) + 13'(x);
    endfunction
    function automatic logic [6:0] idx_to_x(input logic [12:0] idx);
        return 7'(idx % 13'(OLED_W));
    endfunction
    function automatic logic [5:0] idx_to_y(input logic [12:0] idx);
        return 6'(idx / 13'(OLED_W));
    endfunction
endpackage

// File: rtl/canvas_painter_if.sv
// canvas_painter_if: pixel stream, paint controls and cursor status between palette stage and canvas
interface canvas_painter_if;
    import canvas_painter_pkg::*;
    logic [12:0] pixel_index;
    logic [15:0] selected_colour;
    logic draw_en;
    logic menu_active;
    logic btnU;
    logic btnD;
    logic btnL;
    logic btnR;
    logic btnC;
    logic clear_req;
    logic [15:0] curr_pixel_oled;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic busy;
    modport master (
        output pixel_index, selected_colour, draw_en, menu_active,
        output btnU, btnD, btnL, btnR, btnC, clear_req,
        input curr_pixel_oled, cursor_x, cursor_y, busy
    );
    modport slave (
        input pixel_index, selected_colour, draw_en, menu_active,
        input btnU, btnD, btnL, btnR, btnC, clear_req,
        output curr_pixel_oled, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/canvas_painter_ram.sv
// canvas_painter_ram: simple dual-port read-first framebuffer with one registered read port
module canvas_painter_ram
    import canvas_painter_pkg::*;
#(
    parameter int DEPTH = PIX_N,
    parameter int AW = 13,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/canvas_painter.sv
// canvas_painter: 96x64 RGB565 drawing board with button-driven paint cursor and blinking overlay
module canvas_painter
    import canvas_painter_pkg::*;
#(
    parameter int WIDTH = OLED_W,
    parameter int HEIGHT = OLED_H,
    parameter int CANVAS_H = MENU_Y0,
    parameter logic [15:0] BG_COLOUR = WHITE,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input logic CLOCK,
    input logic RESET,
    canvas_painter_if.slave bus
);
    localparam int PIX = WIDTH * HEIGHT;
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    state_t state;
    logic [12:0] clr_addr;
    logic [BW-1:0] blink_cnt;
    logic blink;
    logic clear_d;
    logic ovl_d;
    logic [15:0] rdata;
    logic [3:0] btn;
    logic [3:0] step;
    logic gate;
    logic we;
    logic [12:0] cur_addr;
    logic [12:0] waddr;
    logic [15:0] wdata;
    assign gate = state == IDLE && bus.draw_en && !bus.menu_active;
    assign cur_addr = xy_to_idx(bus.cursor_x, bus.cursor_y);
    assign we = !RESET && (state == CLEAR || (gate && bus.btnC));
    assign waddr = state == CLEAR ? clr_addr : cur_addr;
    assign wdata = state == CLEAR ? BG_COLOUR : bus.selected_colour;
    assign btn = {bus.btnR, bus.btnL, bus.btnD, bus.btnU};
    assign bus.curr_pixel_oled = clear_d ? BG_COLOUR : ovl_d ? ~rdata : rdata;
    canvas_painter_ram #(.DEPTH(PIX)) u_ram (
        .clk(CLOCK),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(bus.pixel_index),
        .rdata(rdata)
    );
    // cnt holds cycles since the press edge; zero means no auto-repeat is armed
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic prev;
        logic [CW-1:0] cnt;
        assign step[i] = gate && btn[i] && (!prev || cnt == CW'(HOLD_CYCLES));
        always_ff @(posedge CLOCK) begin
            if (RESET || !gate) begin
                prev <= !RESET && btn[i];
                cnt <= '0;
            end else begin
                prev <= btn[i];
                cnt <= !btn[i] || (prev && cnt == '0) ? '0 :
                       !prev ? CW'(1) :
                       cnt == CW'(HOLD_CYCLES) ? CW'(HOLD_CYCLES - REPEAT_CYCLES + 1) : cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= CLEAR;
            clr_addr <= '0;
            bus.busy <= 1'b1;
            blink_cnt <= '0;
            blink <= 1'b0;
            clear_d <= 1'b1;
            ovl_d <= 1'b0;
            bus.cursor_x <= 7'(WIDTH / 2);
            bus.cursor_y <= 6'(CANVAS_H / 2);
        end else begin
            blink_cnt <= blink_cnt == BW'(BLINK_CYCLES - 1) ? '0 : blink_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_CYCLES - 1)) blink <= !blink;
            clear_d <= state == CLEAR;
            ovl_d <= blink && bus.draw_en && bus.pixel_index == cur_addr;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == 13'(PIX - 1)) begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
            end else if (bus.clear_req) begin
                state <= CLEAR;
                clr_addr <= '0;
                bus.busy <= 1'b1;
            end
            bus.cursor_y <= step[0] && !step[1] && bus.cursor_y != '0 ? bus.cursor_y - 1'b1 :
                            step[1] && !step[0] && bus.cursor_y != 6'(CANVAS_H - 1) ? bus.cursor_y + 1'b1 :
                            bus.cursor_y;
            bus.cursor_x <= step[2] && !step[3] && bus.cursor_x != '0 ? bus.cursor_x - 1'b1 :
                            step[3] && !step[2] && bus.cursor_x != 7'(WIDTH - 1) ? bus.cursor_x + 1'b1 :
                            bus.cursor_x;
        end
    end
endmodule
